// File: rtl/tdm_demux_1x8.sv
// ============================================================================
// tdm_demux_1x8
// ----------------------------------------------------------------------------
// Receive-side demultiplexer for an 8-channel TDM link. Each valid input
// sample is steered into one of eight channel registers by a slot counter
// that is aligned to the frame-sync marker. Channels hold their last value.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   din         multiplexed sample (WIDTH bits)
//   din_valid   din carries a sample this cycle
//   frame_sync  marks the current sample as slot 0 (qualified by din_valid)
//   D0..D7      channel registers, each held until rewritten
//   dvalid      one-hot pulse, bit k set the cycle after Dk is written
//   slot        slot index the next accepted sample will be written to
//   locked      high once the first frame_sync has been seen
//   frame_done  pulse coincident with dvalid[7]
//   sync_err    pulse when frame_sync arrives at a slot other than 0
// ============================================================================
module tdm_demux_1x8 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] D0,
    output logic [WIDTH-1:0] D1,
    output logic [WIDTH-1:0] D2,
    output logic [WIDTH-1:0] D3,
    output logic [WIDTH-1:0] D4,
    output logic [WIDTH-1:0] D5,
    output logic [WIDTH-1:0] D6,
    output logic [WIDTH-1:0] D7,
    output logic [7:0]       dvalid,
    output logic [2:0]       slot,
    output logic             locked,
    output logic             frame_done,
    output logic             sync_err
);

    localparam logic HUNT   = 1'b0;
    localparam logic LOCKED = 1'b1;

    logic             state;
    logic [WIDTH-1:0] ch [8];

    // NOTE: all state below is sequential and uses non-blocking assignments,
    // so every read of slot/state in this block sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            slot       <= 3'd0;
            dvalid     <= 8'h00;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            // NOTE: the channel bank is reset explicitly because a cleared
            // output is part of the reset state, so it cannot be a RAM.
            for (int i = 0; i < 8; i++) begin
                ch[i] <= '0;
            end
        end else begin
            // Pulses default low; the branches below re-raise them.
            dvalid     <= 8'h00;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;

            if (din_valid) begin
                if (state == HUNT) begin
                    // Unsynchronised samples are dropped until a marker arrives.
                    if (frame_sync) begin
                        ch[0]  <= din;
                        dvalid <= 8'h01;
                        slot   <= 3'd1;
                        state  <= LOCKED;
                    end
                end else if (frame_sync && (slot != 3'd0)) begin
                    // Marker out of place: realign to slot 0. The partially
                    // filled channels are deliberately left stale.
                    ch[0]    <= din;
                    dvalid   <= 8'h01;
                    slot     <= 3'd1;
                    sync_err <= 1'b1;
                end else begin
                    // Normal write; a marker at slot 0 just confirms alignment.
                    ch[slot]   <= din;
                    dvalid     <= 8'h01 << slot;
                    slot       <= slot + 3'd1;
                    frame_done <= (slot == 3'd7);
                end
            end
        end
    end

    assign locked = (state == LOCKED);

    assign D0 = ch[0];
    assign D1 = ch[1];
    assign D2 = ch[2];
    assign D3 = ch[3];
    assign D4 = ch[4];
    assign D5 = ch[5];
    assign D6 = ch[6];
    assign D7 = ch[7];

endmodule

// File: doc/tdm_demux_1x8.md
# tdm_demux_1x8

Time-division demultiplexer that undoes an 8:1 multiplexed stream. Each valid input sample is routed to one of eight registered output channels, selected by an internal slot counter that is aligned to a frame-sync marker. The block sits at the receive end of an 8-channel TDM link. It holds each channel's last value, and it flags frame completion and sync misalignment.

## Interface
Parameters:
- WIDTH, 1, bit width of each sample and of each output channel

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- din  input  WIDTH  multiplexed sample
- din_valid  input  1  din carries a sample this cycle
- frame_sync  input  1  qualified by din_valid; marks the current sample as slot 0
- D0..D7  output  WIDTH each  demultiplexed channel registers; each holds its value until rewritten
- dvalid  output  8  one-cycle pulse; bit k set the cycle after Dk is written
- slot  output  3  slot index the next accepted sample will be written to (S2..S0 order, MSB first)
- locked  output  1  state == LOCKED
- frame_done  output  1  one-cycle pulse, coincident with dvalid[7]
- sync_err  output  1  one-cycle pulse on a resync event

## Operation
- Reset (rst_n low, asynchronous) sets every output to its reset value:
  - D0..D7 = 0, dvalid = 0, slot = 0
  - locked = 0, frame_done = 0, sync_err = 0
  - state = HUNT
- The FSM has two states, HUNT and LOCKED.
- In HUNT:
  - Samples with din_valid=1 and frame_sync=0 are discarded; no output changes.
  - din_valid=1 with frame_sync=1 writes D0 = din, pulses dvalid[0], sets slot = 1 and moves to LOCKED.
- In LOCKED, a sample with din_valid=1 and frame_sync=0:
  - writes D[slot] = din and pulses dvalid[slot];
  - advances slot = (slot + 1) mod 8, wrapping from 7 to 0;
  - pulses frame_done as well when slot was 7.
- In LOCKED, a sample with din_valid=1 and frame_sync=1:
  - If slot == 0, it is a normal slot-0 write and the sync is confirmed.
  - If slot != 0, it is a resync: write D0 = din, pulse dvalid[0] and sync_err, set slot = 1, and do not pulse frame_done. The partially filled channels keep their stale values.
- din_valid=0 changes nothing: slot holds and no pulses are produced. frame_sync without din_valid is ignored in every state.
- Any number of idle cycles between samples is allowed, and the slot position is preserved across them.
- There is no return to HUNT except through reset.
- Exactly one dvalid bit at most is high in any cycle.

## Timing
- All outputs are registered. A sample accepted at rising edge N appears on Dk, dvalid[k], slot, frame_done and sync_err after edge N, and is visible for cycle N+1.
- Latency din → Dk is 1 cycle. Throughput is one sample per clock; back-to-back din_valid is supported.
- dvalid, frame_done and sync_err are single-cycle pulses. They deassert on the next edge unless the next sample re-triggers them.
- locked rises in the same cycle as the dvalid[0] produced by the first frame_sync.
- Asynchronous reset mid-frame clears all state immediately, without waiting for a clock. After rst_n is released, the block is in HUNT and needs a new frame_sync.

## Test plan
- **Reset:** drive rst_n=0 mid-stream with a nonzero din → all outputs 0 and locked=0 immediately, before any clock edge.
- **Hunt discard:** apply three valid samples 0xA without frame_sync, WIDTH=4 → D0..D7 stay 0, dvalid stays 0, locked stays 0.
- **Full frame:** apply sync with din=0, then din=1..7 back-to-back → D0..D7 = 0..7. dvalid walks 0x01→0x80 over 8 cycles, frame_done pulses with dvalid=0x80, and slot wraps to 0.
- **Idle gaps:** repeat the full frame with 2 idle cycles between every sample → same final D values, slot holds during gaps, and no spurious pulses.
- **Early resync:** after slots 0..3 are written with 0x1..0x4, apply frame_sync with din=0xF → sync_err=1, D0=0xF, slot=1, no frame_done. D1..D3 keep 0x2..0x4 and D4..D7 keep their old values.
- **Sync confirm:** apply frame_sync exactly at slot 0 on the second frame → no sync_err, D0 updated, locked stays 1.
